// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the 8-bit microprocessor front end.
//   - opcode encodings (alu_sel values)
//   - instruction field bit positions: [7:5] op, [4:3] rd, [2:1] imm, [0] reserved
//   - sequencer FSM state type
package isa_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_JZD  = 3'b011;
    localparam logic [2:0] OP_JZU  = 3'b100;
    localparam logic [2:0] OP_JD   = 3'b101;
    localparam logic [2:0] OP_JU   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 1;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction memory fetch bus.
//   imem_req   : fetch request, held until imem_valid (master -> slave)
//   imem_addr  : fetch address, stable while imem_req=1 (master -> slave)
//   imem_valid : instruction data valid this cycle (slave -> master)
//   imem_data  : 8-bit instruction word (slave -> master)
interface instr_sequencer_if #(
    parameter int PC_W = 8
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [7:0]      imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/instr_sequencer_regfile.sv
// regfile: NUM_REGS x DATA_W register file.
//   clk, rst_n : clock and synchronous active-low clear of all entries
//   raddr/rdata: combinational read port
//   we/waddr/wdata: synchronous write port
module regfile #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 2,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute front end for the 8-bit microprocessor.
// Owns the PC and register file, fetches over the imem bus, drives the
// combinational ALU and resolves branches/jumps.
//   clk, rst_n      : clock, synchronous active-low reset
//   imem            : fetch bus (master modport)
//   alu_sel/a/b     : opcode, immediate and reg[rd] operand to the ALU
//   alu_out         : ALU result, sampled in EXECUTE
//   pc              : current program counter
//   retire          : high during the EXECUTE cycle of every instruction
//   halted          : sticky, set when op 111 executes
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DATA_W   = 2,
    parameter int NUM_REGS = 4,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.master   imem,
    output logic [2:0]          alu_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [DATA_W-1:0]   alu_out,
    output logic [PC_W-1:0]     pc,
    output logic                retire,
    output logic                halted
);
    localparam int IDX_W = $clog2(NUM_REGS);

    state_t            state_q, state_d;
    logic [7:0]        ir_q;
    logic              req_q;
    logic [PC_W-1:0]   pc_d;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;
    logic [2:0]        op;
    logic [IDX_W-1:0]  rd;
    logic [PC_W-1:0]   imm_pc;
    logic              accept;

    assign op     = ir_q[OP_MSB:OP_LSB];
    assign rd     = IDX_W'(ir_q[RD_MSB:RD_LSB]);
    assign imm_pc = PC_W'(ir_q[IMM_MSB:IMM_LSB]);

    // Only a cycle with the registered request up can accept data, so a
    // valid arriving in the first cycle after reset is ignored.
    assign accept = (state_q == ST_FETCH) && req_q && imem.imem_valid;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .raddr (rd),
        .rdata (rf_rdata),
        .we    (rf_we),
        .waddr (rd),
        .wdata (alu_out)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        rf_we   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (accept) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
                // Branch conditions test alu_b, the reg[rd] value captured in DECODE.
                case (op)
                    OP_PASS, OP_ADDI, OP_SUBI: begin
                        rf_we = 1'b1;
                        pc_d  = pc + PC_W'(1);
                    end
                    OP_JZD:  pc_d = (alu_b == '0) ? pc + imm_pc : pc + PC_W'(1);
                    OP_JZU:  pc_d = (alu_b == '0) ? pc - imm_pc : pc + PC_W'(1);
                    OP_JD:   pc_d = pc + imm_pc;
                    OP_JU:   pc_d = pc - imm_pc;
                    default: state_d = ST_HALT;
                endcase
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc      <= PC_W'(RESET_PC);
            ir_q    <= '0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            halted  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_FETCH);
            if (accept) begin
                ir_q <= imem.imem_data;
            end
            if (state_q == ST_DECODE) begin
                alu_sel <= op;
                alu_a   <= DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
                alu_b   <= rf_rdata;
            end
            if (state_q == ST_EXECUTE) begin
                pc <= pc_d;
                if (op == OP_HALT) halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: self-checking bench for instr_sequencer.
// A small ISA model executes each fetched instruction and queues the expected
// EXECUTE-cycle view (pc, alu_sel, alu_a, alu_b); retires pop and compare.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] alu_sel;
    logic [1:0] alu_a, alu_b, alu_out;
    logic [7:0] pc;
    logic       retire, halted;

    instr_sequencer_if #(.PC_W(8)) bus ();

    instr_sequencer #(
        .PC_W     (8),
        .DATA_W   (2),
        .NUM_REGS (4),
        .RESET_PC (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .imem    (bus),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_out (alu_out),
        .pc      (pc),
        .retire  (retire),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in: pass imm, reg+imm, reg-imm.
    assign alu_out = (alu_sel == 3'b001) ? alu_b + alu_a :
                     (alu_sel == 3'b010) ? alu_b - alu_a : alu_a;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] sel;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] mem [256];
    logic [1:0] mregs [4];
    logic [7:0] mpc;
    int         vectors = 0;
    int         miscompares = 0;
    int         ret_cyc [$];
    int         first_req_cyc;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 2'd0;
        mpc = 8'd0;
        sb.delete();
    endtask

    task automatic model_exec(input logic [7:0] ins);
        exp_t e;
        logic [2:0] op  = ins[7:5];
        logic [1:0] rd  = ins[4:3];
        logic [1:0] imm = ins[2:1];
        logic [1:0] rv  = mregs[rd];
        e.pc = mpc; e.sel = op; e.a = imm; e.b = rv;
        sb.push_back(e);
        case (op)
            3'd0: begin mregs[rd] = imm;      mpc = mpc + 8'd1; end
            3'd1: begin mregs[rd] = rv + imm; mpc = mpc + 8'd1; end
            3'd2: begin mregs[rd] = rv - imm; mpc = mpc + 8'd1; end
            3'd3: mpc = (rv == 2'd0) ? mpc + {6'd0, imm} : mpc + 8'd1;
            3'd4: mpc = (rv == 2'd0) ? mpc - {6'd0, imm} : mpc + 8'd1;
            3'd5: mpc = mpc + {6'd0, imm};
            3'd6: mpc = mpc - {6'd0, imm};
            default: ;
        endcase
    endtask

    task automatic do_reset();
        bus.imem_valid = 1'b0;
        bus.imem_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Memory responder + scoreboard loop; runs until the DUT halts.
    task automatic run_prog(input int delay, input int budget);
        int wcnt = 0;
        int n = 0;
        bit done = 1'b0;
        exp_t e;
        ret_cyc.delete();
        first_req_cyc = -1;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (retire) begin
                ret_cyc.push_back(n);
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL retire_unexpected: pc=%0d, no instruction outstanding", pc);
                end else begin
                    e = sb.pop_front();
                    if (pc !== e.pc || alu_sel !== e.sel || alu_a !== e.a || alu_b !== e.b) begin
                        miscompares++;
                        $display("FAIL execute_view: got pc=%0d sel=%0d a=%0d b=%0d, want pc=%0d sel=%0d a=%0d b=%0d",
                                 pc, alu_sel, alu_a, alu_b, e.pc, e.sel, e.a, e.b);
                    end
                end
            end
            if (bus.imem_req) begin
                if (first_req_cyc < 0) first_req_cyc = n;
                vectors++;
                if (bus.imem_addr !== mpc) begin
                    miscompares++;
                    $display("FAIL fetch_addr: got %0d want %0d", bus.imem_addr, mpc);
                end
                if (wcnt == delay) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_data  = mem[bus.imem_addr];
                    model_exec(mem[bus.imem_addr]);
                    wcnt = 0;
                end else begin
                    bus.imem_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                if (wcnt != 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_dropped: req=0 after %0d wait cycles, want 1", wcnt);
                end
                bus.imem_valid = 1'b0;
                wcnt = 0;
            end
            if (halted === 1'b1) done = 1'b1;
        end
        bus.imem_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL run_timeout: halted=%0b after %0d cycles, want 1", halted, budget);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d entries unretired, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (pc !== 8'd0 || bus.imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 ||
            alu_sel !== 3'd0 || alu_a !== 2'd0 || alu_b !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_values: got pc=%0d req=%0b ret=%0b halt=%0b sel=%0d a=%0d b=%0d, want all 0",
                     pc, bus.imem_req, retire, halted, alu_sel, alu_a, alu_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL req_after_reset: got req=%0b addr=%0d, want req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap_add();
        clear_mem();
        mem[0] = 8'b000_01_11_0;  // r1 = 3
        mem[1] = 8'b001_01_10_0;  // r1 += 2 -> 1
        mem[2] = 8'b001_01_00_0;  // r1 += 0, exposes r1 on alu_b
        mem[3] = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 200);
        vectors++;
        if (ret_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_retire_count: got %0d want 4", ret_cyc.size());
        end else begin
            vectors++;
            if (ret_cyc[0] - first_req_cyc != 2 || ret_cyc[1] - ret_cyc[0] != 3) begin
                miscompares++;
                $display("FAIL min_latency: got first=%0d spacing=%0d, want 2 and 3",
                         ret_cyc[0] - first_req_cyc, ret_cyc[1] - ret_cyc[0]);
            end
        end
        vectors++;
        if (pc !== 8'd3) begin
            miscompares++;
            $display("FAIL wrap_pc: got %0d want 3", pc);
        end
    endtask

    task automatic test_cond_jump();
        clear_mem();
        mem[0] = 8'b011_00_11_0;  // r0==0 -> pc=3
        mem[3] = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 200);
        vectors++;
        if (pc !== 8'd3) begin
            miscompares++;
            $display("FAIL jzd_taken_pc: got %0d want 3", pc);
        end
        clear_mem();
        mem[0] = 8'b000_00_01_0;  // r0 = 1
        mem[1] = 8'b011_00_11_0;  // not taken -> pc=2
        mem[2] = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 200);
        vectors++;
        if (pc !== 8'd2) begin
            miscompares++;
            $display("FAIL jzd_not_taken_pc: got %0d want 2", pc);
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem[0]   = 8'b100_01_10_0;  // r1==0 -> pc = 0-2 = 254; later falls through
        mem[254] = 8'b000_01_01_0;  // r1 = 1
        mem[255] = 8'b000_10_11_0;  // r2 = 3, pc wraps to 0
        mem[1]   = 8'b001_10_00_0;  // exposes r2
        mem[2]   = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 300);
        vectors++;
        if (pc !== 8'd2) begin
            miscompares++;
            $display("FAIL pc_wrap_up_pc: got %0d want 2", pc);
        end
        clear_mem();
        mem[0]   = 8'b000_00_00_0;
        mem[1]   = 8'b110_00_11_0;  // pc = 1-3 = 254
        mem[254] = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 200);
        vectors++;
        if (pc !== 8'd254) begin
            miscompares++;
            $display("FAIL ju_wrap_pc: got %0d want 254", pc);
        end
    endtask

    task automatic test_wait_states();
        clear_mem();
        mem[0] = 8'b000_01_11_0;
        mem[1] = 8'b111_00_00_0;
        do_reset();
        run_prog(4, 300);
        vectors++;
        if (ret_cyc.size() < 1 || ret_cyc[0] - first_req_cyc != 6) begin
            miscompares++;
            $display("FAIL wait_latency: got %0d want 6",
                     (ret_cyc.size() < 1) ? -1 : ret_cyc[0] - first_req_cyc);
        end
    endtask

    task automatic test_halt();
        int extra_ret = 0;
        clear_mem();
        mem[0] = 8'b101_00_11_0;  // pc = 3
        mem[3] = 8'b101_00_10_0;  // pc = 5
        mem[5] = 8'b111_00_00_0;
        do_reset();
        run_prog(0, 200);
        vectors++;
        if (ret_cyc.size() != 3) begin
            miscompares++;
            $display("FAIL halt_retire_count: got %0d want 3", ret_cyc.size());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (retire === 1'b1) extra_ret++;
            vectors++;
            if (bus.imem_req !== 1'b0 || pc !== 8'd5 || halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_hold: got req=%0b pc=%0d halted=%0b, want 0 5 1", bus.imem_req, pc, halted);
            end
        end
        vectors++;
        if (extra_ret != 0) begin
            miscompares++;
            $display("FAIL halt_retire_after: got %0d want 0", extra_ret);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (halted !== 1'b0 || pc !== 8'd0) begin
            miscompares++;
            $display("FAIL halt_reset: got halted=%0b pc=%0d, want 0 0", halted, pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        clear_mem();
        do_reset();
        while (bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_fetch_req: got req=%0b want 1", bus.imem_req);
        end
        bus.imem_valid = 1'b1;
        bus.imem_data  = 8'b000_01_11_0;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (pc !== 8'd0 || bus.imem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 ||
            alu_sel !== 3'd0 || alu_a !== 2'd0 || alu_b !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_fetch_reset: got pc=%0d req=%0b ret=%0b halt=%0b sel=%0d a=%0d b=%0d, want all 0",
                     pc, bus.imem_req, retire, halted, alu_sel, alu_a, alu_b);
        end
        // Late valid while req is still low must be ignored.
        rst_n = 1'b1;
        bus.imem_data = 8'b111_00_00_0;
        @(negedge clk);
        vectors++;
        if (bus.imem_req !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL late_valid_ignored: got req=%0b halted=%0b, want 1 0", bus.imem_req, halted);
        end
        bus.imem_valid = 1'b0;
        model_reset();
        mem[0] = 8'b001_01_00_0;  // r1 must still be 0
        mem[1] = 8'b111_00_00_0;
        run_prog(0, 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_data  = 8'h00;
        clear_mem();
        model_reset();
        test_reset();
        test_wrap_add();
        test_cond_jump();
        test_pc_wrap();
        test_wait_states();
        test_halt();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/decode/sequencing front end for the 8-bit microprocessor; it is the producer side of the ALU opcode interface.
- Owns the program counter and a small register file.
- Fetches 8-bit instructions over a req/valid handshake, drives opcode and operands to the combinational ALU, captures its result, and computes the next PC (branch/jump resolution lives here, not in the ALU).

Parameters:
- PC_W, 8, program counter / instruction address width (modulo arithmetic)
- DATA_W, 2, register/immediate data width
- NUM_REGS, 4, register file depth (index = 2 bits)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  PC_W  fetch address (= pc), stable while imem_req=1
- imem_valid  in  1  instruction data valid this cycle
- imem_data  in  8  instruction: [7:5] op, [4:3] rd, [2:1] imm, [0] reserved (ignored)
- alu_sel  out  3  opcode to ALU
- alu_a  out  DATA_W  immediate operand to ALU
- alu_b  out  DATA_W  register operand reg[rd] to ALU
- alu_out  in  DATA_W  ALU result (combinational from alu_sel/a/b)
- pc  out  PC_W  current program counter
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high once op 111 executes; sticky until reset

Behaviour:
- Reset (rst_n=0 at a clk edge): state=FETCH, pc=RESET_PC, all regs=0, ir=0, alu_sel=000, alu_a=0, alu_b=0, retire=0, halted=0. imem_req is registered and low in the first cycle after reset; it rises the following cycle. A reset mid-fetch drops imem_req on the next cycle, and any late imem_valid is ignored.
- FSM states: FETCH, DECODE, EXECUTE, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid=1, latch imem_data into ir and go to DECODE. imem_valid outside FETCH is ignored.
  - DECODE: register alu_sel=ir[7:5], alu_a=ir[2:1], alu_b=reg[ir[4:3]], then go to EXECUTE.
  - EXECUTE: sample alu_out, update regs/pc, pulse retire, then return to FETCH; for op 111 go to HALT instead.
  - HALT: stays in HALT until reset; no fetches are issued.
- Minimum latency: 3 cycles per instruction (FETCH with valid in the first cycle, DECODE, EXECUTE). Each imem wait state adds one cycle.
- Opcode semantics in EXECUTE (imm is unsigned 0..3, rv = reg[rd]):
  - 000 pass: reg[rd]=imm; pc+=1
  - 001 addi: reg[rd]=alu_out (rv+imm mod 4); pc+=1
  - 010 subi: reg[rd]=alu_out (rv-imm mod 4); pc+=1
  - 011 cond jump down: if rv==0, pc+=imm, else pc+=1
  - 100 cond jump up: if rv==0, pc-=imm, else pc+=1
  - 101 jump down: pc+=imm
  - 110 jump up: pc-=imm
  - 111 halt: halted=1, pc unchanged, no register write
- Register writes use alu_out only for ops 001 and 010. Op 000 writes alu_out as well, which equals imm.
- PC arithmetic is modulo 2^PC_W: 255+1=0, and 0-3=253.
- A jump with imm=0 yields a self-loop. This is legal and is not detected.
- Branch conditions use the register value latched into alu_b in DECODE. That is the current value, because there is no overlap between instructions.
- retire is asserted exactly in the EXECUTE cycle, including for halt.
- alu_sel/a/b hold their values from DECODE until the next DECODE.

Decomposition:
- Shared package isa_pkg:
  - opcode localparams OP_PASS=000, OP_ADDI=001, OP_SUBI=010, OP_JZD=011, OP_JZU=100, OP_JD=101, OP_JU=110, OP_HALT=111
  - instruction field bit positions
  - FSM state encoding
- One sub-module, regfile: NUM_REGS x DATA_W, one combinational read port, one synchronous write port, synchronous active-low clear.

Test Plan:
- Reset, then program [0]=000_01_11_0 (pass r1=3), [1]=001_01_10_0 (addi r1+=2) -> r1=1 (wrap); retire pulses at cycles 3 and 6; pc=2.
- Program [0]=011_00_11_0 with r0=0 -> pc=3. Reload with r0=1 -> pc=1. Check alu_sel=011 and alu_b matches r0 during EXECUTE.
- Set pc=254 (via jumps) and execute 000 at 254 and 255 -> next fetch at 0; 110 with imm=3 at pc=1 -> pc=254.
- imem_valid delayed by 4 cycles -> imem_req held high and imem_addr stable throughout; instruction retires exactly 4 cycles later than nominal.
- Op 111 at pc=5 -> halted=1 and retire pulses once; imem_req stays 0 for 20 cycles; pc=5; rst_n=0 clears halted and pc returns to 0.
- Assert rst_n=0 during FETCH with valid arriving in the same cycle -> instruction discarded; all outputs at reset values the next cycle.
